d_sram_to_sram_like: RTL and testbench



---
 rtl/d_sram_to_sram_like.sv | 230 +++++++++++++++++++++++
 tb/tb_d_sram_to_sram_like.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/d_sram_to_sram_like.sv
// d_sram_to_sram_like: data-side adapter from the core's single-cycle SRAM
// port to the two-phase SRAM-like bus (req/addr_ok, then data_ok).
// It raises the data stall while an access is outstanding and holds the
// returned read data until the pipeline releases its global stall.
// Optional build macro: D_BRIDGE_PERF_CNT_EN adds request/stall counters.
module d_sram_to_sram_like #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          data_sram_en,
    input  logic [3:0]    data_sram_wen,
    input  logic [AW-1:0] data_sram_addr,
    input  logic [DW-1:0] data_sram_wdata,
    output logic [DW-1:0] data_sram_rdata,
    output logic          d_stall,
    input  logic          longest_stall,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [AW-1:0] data_addr,
    output logic [DW-1:0] data_wdata,
    input  logic          data_addr_ok,
    input  logic          data_data_ok,
    input  logic [DW-1:0] data_rdata
`ifdef D_BRIDGE_PERF_CNT_EN
    ,
    output logic [31:0]   perf_req_cnt,
    output logic [31:0]   perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    // Byte enables -> {size, low address bits}; unusual patterns fall back to a word
    function automatic logic [3:0] wen_decode(input logic [3:0] wen);
        logic [3:0] res;
        case (wen)
            4'b1111: res = {2'd2, 2'b00};
            4'b0011: res = {2'd1, 2'b00};
            4'b1100: res = {2'd1, 2'b10};
            4'b0001: res = {2'd0, 2'b00};
            4'b0010: res = {2'd0, 2'b01};
            4'b0100: res = {2'd0, 2'b10};
            4'b1000: res = {2'd0, 2'b11};
            default: res = {2'd2, 2'b00};
        endcase
        return res;
    endfunction

    logic [3:0]    dec_s;
    logic          cur_wr_s;
    logic [1:0]    cur_size_s;
    logic [AW-1:0] cur_addr_s;

    logic          lat_wr_r;
    logic [1:0]    lat_size_r;
    logic [AW-1:0] lat_addr_r;
    logic [DW-1:0] lat_wdata_r;

    logic          req_s;
    logic          wr_s;
    logic [1:0]    size_s;
    logic [AW-1:0] addr_s;
    logic [DW-1:0] wdata_s;
    logic          stall_s;

    // Bus request fields derived directly from the core's current request
    always_comb begin
        dec_s      = wen_decode(data_sram_wen);
        cur_wr_s   = |data_sram_wen;
        cur_size_s = dec_s[3:2];
        cur_addr_s = {data_sram_addr[AW-1:2], dec_s[1:0]};
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; bus responses outside their own phase are ignored
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (data_sram_en && data_addr_ok) begin
                    state_nxt_s = WAIT_DATA;
                end else if (data_sram_en) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (data_addr_ok) begin
                    state_nxt_s = WAIT_DATA;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT_DATA: begin
                if (data_data_ok) begin
                    // A flushed access (en dropped) finishes on the bus but skips DONE
                    state_nxt_s = data_sram_en ? DONE : IDLE;
                end else begin
                    state_nxt_s = WAIT_DATA;
                end
            end
            DONE: begin
                if (longest_stall) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Latch the request while idle so it stays stable until accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_wr_r    <= 1'b0;
            lat_size_r  <= 2'd0;
            lat_addr_r  <= '0;
            lat_wdata_r <= '0;
        end else if (state_r == IDLE && data_sram_en) begin
            lat_wr_r    <= cur_wr_s;
            lat_size_r  <= cur_size_s;
            lat_addr_r  <= cur_addr_s;
            lat_wdata_r <= data_sram_wdata;
        end else begin
            lat_wr_r    <= lat_wr_r;
            lat_size_r  <= lat_size_r;
            lat_addr_r  <= lat_addr_r;
            lat_wdata_r <= lat_wdata_r;
        end
    end

    // Capture returned data only while waiting for it; hold otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_sram_rdata <= '0;
        end else if (state_r == WAIT_DATA && data_data_ok) begin
            data_sram_rdata <= data_rdata;
        end else begin
            data_sram_rdata <= data_sram_rdata;
        end
    end

    // Per-state output decode: live fields in IDLE, latched fields afterwards
    always_comb begin
        req_s   = 1'b0;
        wr_s    = lat_wr_r;
        size_s  = lat_size_r;
        addr_s  = lat_addr_r;
        wdata_s = lat_wdata_r;
        stall_s = 1'b0;
        case (state_r)
            IDLE: begin
                req_s   = data_sram_en;
                wr_s    = cur_wr_s;
                size_s  = cur_size_s;
                addr_s  = cur_addr_s;
                wdata_s = data_sram_wdata;
                stall_s = data_sram_en;
            end
            REQ: begin
                req_s   = 1'b1;
                stall_s = 1'b1;
            end
            WAIT_DATA: begin
                stall_s = 1'b1;
            end
            DONE: begin
                stall_s = 1'b0;
            end
            default: begin
                req_s   = 1'b0;
                stall_s = 1'b0;
            end
        endcase
    end

    // Force every combinational output low for as long as reset is held
    always_comb begin
        if (!rst) begin
            data_req   = 1'b0;
            data_wr    = 1'b0;
            data_size  = 2'd0;
            data_addr  = '0;
            data_wdata = '0;
            d_stall    = 1'b0;
        end else begin
            data_req   = req_s;
            data_wr    = wr_s;
            data_size  = size_s;
            data_addr  = addr_s;
            data_wdata = wdata_s;
            d_stall    = stall_s;
        end
    end

`ifdef D_BRIDGE_PERF_CNT_EN
    // Free-running wrap-around counters of accepted requests and stall cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_req_cnt   <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            perf_req_cnt   <= perf_req_cnt + ((data_req && data_addr_ok) ? 32'd1 : 32'd0);
            perf_stall_cnt <= perf_stall_cnt + (d_stall ? 32'd1 : 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_d_sram_to_sram_like.sv
// Directed bench for d_sram_to_sram_like. Inputs change on the falling edge
// and outputs are sampled 1 ns later, well clear of the rising edge.
module tb_d_sram_to_sram_like;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] sram_rdata;
    logic        d_stall;
    logic        longest;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] bus_rdata;
`ifdef D_BRIDGE_PERF_CNT_EN
    logic [31:0] perf_req_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    d_sram_to_sram_like dut (
        .clk            (clk),
        .rst            (rst),
        .data_sram_en   (en),
        .data_sram_wen  (wen),
        .data_sram_addr (addr),
        .data_sram_wdata(wdata),
        .data_sram_rdata(sram_rdata),
        .d_stall        (d_stall),
        .longest_stall  (longest),
        .data_req       (data_req),
        .data_wr        (data_wr),
        .data_size      (data_size),
        .data_addr      (data_addr),
        .data_wdata     (data_wdata),
        .data_addr_ok   (addr_ok),
        .data_data_ok   (data_ok),
        .data_rdata     (bus_rdata)
`ifdef D_BRIDGE_PERF_CNT_EN
        ,
        .perf_req_cnt   (perf_req_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    // One access with addr_ok in the issue cycle and data_ok one cycle later
    task automatic do_access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input logic [31:0] ea, input logic [31:0] prev,
                             input logic [1:0] es, input logic ew);
        next();
        en = 1'b1; wen = w; addr = a; wdata = wd; addr_ok = 1'b1; data_ok = 1'b0; longest = 1'b0;
        #1;
        check("acc_req", data_req, 1);
        check("acc_wr", data_wr, ew);
        check("acc_size", data_size, es);
        check("acc_addr", data_addr, ea);
        check("acc_wdata", data_wdata, wd);
        check("acc_stall_issue", d_stall, 1);
        check("acc_rdata_hold", sram_rdata, prev);
        next();
        addr_ok = 1'b0; data_ok = 1'b1; bus_rdata = ew ? prev : rd;
        #1;
        check("acc_req_wait", data_req, 0);
        check("acc_stall_wait", d_stall, 1);
        next();
        data_ok = 1'b0;
        #1;
        check("acc_stall_done", d_stall, 0);
        check("acc_req_done", data_req, 0);
        check("acc_rdata", sram_rdata, ew ? prev : rd);
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; wen = 4'b1111; addr = 32'h1234_5678; wdata = 32'hA5A5_A5A5;
        longest = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; bus_rdata = 32'h0;
        next(); #1;
        check("rst_req", data_req, 0);
        check("rst_addr", data_addr, 0);
        check("rst_wdata", data_wdata, 0);
        check("rst_stall", d_stall, 0);
        check("rst_rdata", sram_rdata, 0);
        next();
        rst = 1'b1; en = 1'b0;
        #1;
        check("idle_stall", d_stall, 0);

        // Aligned word read, minimum latency
        do_access(4'b0000, 32'h8000_0013, 32'h0, 32'hDEAD_BEEF, 32'h8000_0010, 32'h0, 2'd2, 1'b0);

        // Half-word write, addr_ok delayed 3 cycles; core inputs scrambled to prove latching
        next();
        en = 1'b1; wen = 4'b1100; addr = 32'h0000_1000; wdata = 32'h1234_0000; addr_ok = 1'b0;
        #1;
        check("w_req0", data_req, 1);
        check("w_addr0", data_addr, 32'h0000_1002);
        check("w_size0", data_size, 1);
        check("w_wr0", data_wr, 1);
        for (int i = 0; i < 3; i++) begin
            next();
            wen = 4'b1111; addr = 32'hFFFF_FFFC; wdata = 32'hFFFF_FFFF; addr_ok = (i == 2);
            #1;
            check("w_req_held", data_req, 1);
            check("w_addr_held", data_addr, 32'h0000_1002);
            check("w_size_held", data_size, 1);
            check("w_wdata_held", data_wdata, 32'h1234_0000);
            check("w_stall_held", d_stall, 1);
        end
        next(); addr_ok = 1'b0; #1;
        check("w_req_wait", data_req, 0);
        check("w_stall_wait", d_stall, 1);
        next(); data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF; #1;
        check("w_stall_dok", d_stall, 1);
        next(); data_ok = 1'b0; #1;
        check("w_stall_done", d_stall, 0);
        check("w_req_done", data_req, 0);

        // Size/offset decode of byte-enable patterns
        do_access(4'b0100, 32'h0000_2000, 32'h00AB_0000, 32'h0, 32'h0000_2002, 32'hDEAD_BEEF, 2'd0, 1'b1);
        do_access(4'b0101, 32'h0000_2000, 32'h00CD_00EF, 32'h0, 32'h0000_2000, 32'hDEAD_BEEF, 2'd2, 1'b1);
        do_access(4'b1000, 32'h0000_2001, 32'h7700_0000, 32'h0, 32'h0000_2003, 32'hDEAD_BEEF, 2'd0, 1'b1);
        do_access(4'b0011, 32'h0000_2002, 32'h0000_5566, 32'h0, 32'h0000_2000, 32'hDEAD_BEEF, 2'd1, 1'b1);
        do_access(4'b1111, 32'h0000_2003, 32'h0102_0304, 32'h0, 32'h0000_2000, 32'hDEAD_BEEF, 2'd2, 1'b1);

        // data_ok while the global stall persists three more cycles
        next(); en = 1'b1; wen = 4'b0000; addr = 32'h0000_0104; addr_ok = 1'b1; #1;
        check("ls_addr", data_addr, 32'h0000_0104);
        check("ls_stall0", d_stall, 1);
        next(); addr_ok = 1'b0; data_ok = 1'b1; bus_rdata = 32'h0BAD_F00D; longest = 1'b1; #1;
        check("ls_stall1", d_stall, 1);
        for (int i = 0; i < 3; i++) begin
            next(); data_ok = 1'b1; addr_ok = 1'b1; bus_rdata = 32'hFFFF_0000; #1;
            check("ls_done_stall", d_stall, 0);
            check("ls_done_req", data_req, 0);
            check("ls_done_rdata", sram_rdata, 32'h0BAD_F00D);
        end
        next(); data_ok = 1'b0; addr_ok = 1'b0; longest = 1'b0; #1;
        check("ls_release_rdata", sram_rdata, 32'h0BAD_F00D);
        do_access(4'b0000, 32'h0000_0040, 32'h0, 32'h1357_9BDF, 32'h0000_0040, 32'h0BAD_F00D, 2'd2, 1'b0);

        // Flush: en drops in WAIT_DATA; result captured, no DONE
        next(); en = 1'b1; wen = 4'b0000; addr = 32'h0000_3004; addr_ok = 1'b1; #1;
        check("fl_stall0", d_stall, 1);
        next(); en = 1'b0; addr_ok = 1'b0; #1;
        check("fl_stall_wait", d_stall, 1);
        check("fl_req_wait", data_req, 0);
        next(); data_ok = 1'b1; bus_rdata = 32'h55AA_55AA; #1;
        check("fl_stall_dok", d_stall, 1);
        do_access(4'b0001, 32'h0000_0050, 32'h0000_00AB, 32'h0, 32'h0000_0050, 32'h55AA_55AA, 2'd0, 1'b1);

        // Reset pulse during REQ
        next(); en = 1'b1; wen = 4'b0011; addr = 32'h0000_2000; wdata = 32'h0000_BEEF; addr_ok = 1'b0; #1;
        check("rr_req0", data_req, 1);
        next(); #1;
        check("rr_req1", data_req, 1);
        #2 rst = 1'b0; #1;
        check("rr_req", data_req, 0);
        check("rr_wr", data_wr, 0);
        check("rr_size", data_size, 0);
        check("rr_addr", data_addr, 0);
        check("rr_wdata", data_wdata, 0);
        check("rr_stall", d_stall, 0);
        check("rr_rdata", sram_rdata, 0);
        next(); rst = 1'b1; en = 1'b0; #1;
        check("rr_idle_req", data_req, 0);
        check("rr_idle_stall", d_stall, 0);
        do_access(4'b0000, 32'h0000_0600, 32'h0, 32'h0000_0001, 32'h0000_0600, 32'h0, 2'd2, 1'b0);
        do_access(4'b0000, 32'h0000_0604, 32'h0, 32'h0000_0002, 32'h0000_0604, 32'h0000_0001, 2'd2, 1'b0);
        do_access(4'b0000, 32'h0000_060A, 32'h0, 32'h0000_0003, 32'h0000_0608, 32'h0000_0002, 2'd2, 1'b0);
        do_access(4'b0000, 32'h0000_060F, 32'h0, 32'h0000_0004, 32'h0000_060C, 32'h0000_0003, 2'd2, 1'b0);
        do_access(4'b0000, 32'h0000_0610, 32'h0, 32'h0000_0005, 32'h0000_0610, 32'h0000_0004, 2'd2, 1'b0);
`ifdef D_BRIDGE_PERF_CNT_EN
        check("perf_req_cnt", perf_req_cnt, 5);
        check("perf_stall_cnt", perf_stall_cnt, 10);
`endif
        en = 1'b0;
        next();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
